// File: rtl/cam_pkg.sv
// cam_pkg
// Shared definitions for the OV7670 capture path and the VGA read side.
//   - cap_state_t      : capture sequencer states
//   - SCREEN_WIDTH/HEIGHT : frame buffer geometry (176x144, RGB332)
//   - rgb565_to_rgb332 : packs the two camera bytes of one pixel into one byte
package cam_pkg;

    localparam int SCREEN_WIDTH  = 176;
    localparam int SCREEN_HEIGHT = 144;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    // The camera sends RRRRRGGG then GGGBBBBB. Keep the top three red bits,
    // the top three green bits (low bits of the first byte) and the top two
    // blue bits of the second byte.
    function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi_byte,
                                                    input logic [7:0] lo_byte);
        return {hi_byte[7:5], hi_byte[2:0], lo_byte[4:3]};
    endfunction

endpackage

// File: rtl/cam_edge_sync.sv
// cam_edge_sync
// Registers the camera VSYNC/HREF/DATA pins once and derives edge strobes
// from the registered copies.
// Ports:
//   clk, rst        : PCLK and synchronous active-high reset
//   vsync_in/href_in/data_in : raw camera pins
//   href_r, data_r  : registered HREF and DATA
//   vs_fall, vs_rise, href_fall : one-cycle edge strobes
module cam_edge_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       href_in,
    input  logic [7:0] data_in,
    output logic       href_r,
    output logic [7:0] data_r,
    output logic       vs_fall,
    output logic       vs_rise,
    output logic       href_fall
);

    logic       vsync_q, vsync_d;
    logic       vsync_prev_q, vsync_prev_d;
    logic       href_q, href_d;
    logic       href_prev_q, href_prev_d;
    logic [7:0] data_q, data_d;

    // Sample the pins and shift the previous registered value into history.
    always_comb begin
        vsync_d      = vsync_in;
        href_d       = href_in;
        data_d       = data_in;
        vsync_prev_d = vsync_q;
        href_prev_d  = href_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            href_q       <= 1'b0;
            href_prev_q  <= 1'b0;
            data_q       <= 8'd0;
        end else begin
            vsync_q      <= vsync_d;
            vsync_prev_q <= vsync_prev_d;
            href_q       <= href_d;
            href_prev_q  <= href_prev_d;
            data_q       <= data_d;
        end
    end

    assign href_r    = href_q;
    assign data_r    = data_q;
    assign vs_fall   = vsync_prev_q & ~vsync_q;
    assign vs_rise   = ~vsync_prev_q & vsync_q;
    assign href_fall = href_prev_q & ~href_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl
// Sequences one OV7670 frame into the RGB332 frame buffer write port.
// Ports:
//   CLOCK, RESET       : camera PCLK, synchronous active-high reset
//   VSYNC, HREF, DATA  : camera pins (VSYNC high = vertical blank)
//   START, CONTINUOUS  : one-shot arm / automatic re-arm
//   W_EN, W_ADDR, PIXEL_COLOR : registered memory write port
//   BUSY               : sequencer not idle
//   FRAME_DONE         : one-cycle end-of-frame pulse
//   FRAME_ERR          : sticky, a frame had the wrong number of lines
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int WIDTH  = SCREEN_WIDTH,
    parameter int HEIGHT = SCREEN_HEIGHT,
    parameter int ADDR_W = 15
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        DATA,
    input  logic              START,
    input  logic              CONTINUOUS,
    output logic              W_EN,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        PIXEL_COLOR,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              FRAME_ERR
);

    localparam int X_W  = $clog2(WIDTH + 1);
    localparam int Y_W  = $clog2(HEIGHT + 2);
    // One spare bit so line_base can step past the last line without wrapping.
    localparam int LB_W = ADDR_W + 1;

    localparam logic [X_W-1:0]  X_LIMIT = X_W'(WIDTH);
    localparam logic [Y_W-1:0]  Y_LIMIT = Y_W'(HEIGHT);
    localparam logic [Y_W-1:0]  Y_SAT   = Y_W'(HEIGHT + 1);
    localparam logic [LB_W-1:0] LB_STEP = LB_W'(WIDTH);

    logic       href_r, vs_fall, vs_rise, href_fall;
    logic [7:0] data_r;

    cam_edge_sync u_edge_sync (
        .clk       (CLOCK),
        .rst       (RESET),
        .vsync_in  (VSYNC),
        .href_in   (HREF),
        .data_in   (DATA),
        .href_r    (href_r),
        .data_r    (data_r),
        .vs_fall   (vs_fall),
        .vs_rise   (vs_rise),
        .href_fall (href_fall)
    );

    cap_state_t        state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [LB_W-1:0]   line_base_q, line_base_d;
    logic              byte_phase_q, byte_phase_d;
    logic [7:0]        b1_q, b1_d;
    logic              w_en_q, w_en_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [7:0]        pixel_color_q, pixel_color_d;
    logic              frame_err_q, frame_err_d;

    // Sequencer and pixel/line counters. y saturates one past HEIGHT so an
    // overlong frame is still distinguishable from a correct one at DONE.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        line_base_d   = line_base_q;
        byte_phase_d  = byte_phase_q;
        b1_d          = b1_q;
        w_en_d        = 1'b0;
        w_addr_d      = w_addr_q;
        pixel_color_d = pixel_color_q;
        frame_err_d   = frame_err_q;

        unique case (state_q)
            IDLE: begin
                if (START || CONTINUOUS) begin
                    state_d = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_d      = CAPTURE;
                    x_d          = '0;
                    y_d          = '0;
                    line_base_d  = '0;
                    byte_phase_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (vs_rise) begin
                    // End of frame wins over any byte arriving now; a partial
                    // line still counts toward the line total.
                    state_d      = DONE;
                    byte_phase_d = 1'b0;
                    if (x_q != '0) begin
                        x_d = '0;
                        if (y_q < Y_SAT) begin
                            y_d         = y_q + Y_W'(1);
                            line_base_d = line_base_q + LB_STEP;
                        end
                    end
                end else begin
                    if (href_r) begin
                        byte_phase_d = ~byte_phase_q;
                        if (!byte_phase_q) begin
                            b1_d = data_r;
                        end else if (x_q < X_LIMIT) begin
                            x_d = x_q + X_W'(1);
                            if (y_q < Y_LIMIT) begin
                                w_en_d        = 1'b1;
                                w_addr_d      = ADDR_W'(line_base_q + LB_W'(x_q));
                                pixel_color_d = rgb565_to_rgb332(b1_q, data_r);
                            end
                        end
                    end
                    // Uses x_d so a pixel finishing this cycle is counted
                    // before the line advances.
                    if (href_fall) begin
                        byte_phase_d = 1'b0;
                        if (x_d != '0) begin
                            x_d = '0;
                            if (y_q < Y_SAT) begin
                                y_d         = y_q + Y_W'(1);
                                line_base_d = line_base_q + LB_STEP;
                            end
                        end
                    end
                end
            end
            DONE: begin
                if (y_q != Y_LIMIT) begin
                    frame_err_d = 1'b1;
                end
                state_d = CONTINUOUS ? WAIT_VS : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            line_base_q   <= '0;
            byte_phase_q  <= 1'b0;
            b1_q          <= 8'd0;
            w_en_q        <= 1'b0;
            w_addr_q      <= '0;
            pixel_color_q <= 8'd0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_base_q   <= line_base_d;
            byte_phase_q  <= byte_phase_d;
            b1_q          <= b1_d;
            w_en_q        <= w_en_d;
            w_addr_q      <= w_addr_d;
            pixel_color_q <= pixel_color_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign W_EN        = w_en_q;
    assign W_ADDR      = w_addr_q;
    assign PIXEL_COLOR = pixel_color_q;
    assign BUSY        = (state_q != IDLE);
    assign FRAME_DONE  = (state_q == DONE);
    assign FRAME_ERR   = frame_err_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl
// Directed bench for cam_capture_ctrl. A frame-level model turns every line
// the bench sends into the list of memory writes that must appear, and a
// monitor compares each DUT write against that list.
module tb_cam_capture_ctrl;

    localparam int W = 176;
    localparam int H = 144;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        VSYNC;
    logic        HREF;
    logic [7:0]  DATA;
    logic        START;
    logic        CONTINUOUS;
    logic        W_EN;
    logic [14:0] W_ADDR;
    logic [7:0]  PIXEL_COLOR;
    logic        BUSY;
    logic        FRAME_DONE;
    logic        FRAME_ERR;

    cam_capture_ctrl #(
        .WIDTH  (W),
        .HEIGHT (H),
        .ADDR_W (15)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .VSYNC       (VSYNC),
        .HREF        (HREF),
        .DATA        (DATA),
        .START       (START),
        .CONTINUOUS  (CONTINUOUS),
        .W_EN        (W_EN),
        .W_ADDR      (W_ADDR),
        .PIXEL_COLOR (PIXEL_COLOR),
        .BUSY        (BUSY),
        .FRAME_DONE  (FRAME_DONE),
        .FRAME_ERR   (FRAME_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        int addr;
        int color;
    } wr_t;

    int   compared   = 0;
    int   mismatched = 0;
    wr_t  expQ[$];
    wr_t  monE;
    bit   monitorOn  = 1'b0;
    int   writeCount = 0;
    int   lastAddr   = 0;
    int   maxAddr    = 0;
    int   doneCount  = 0;
    logic busyAfterDone = 1'b0;
    logic doneSeenPrev  = 1'b0;
    bit   grabFirst  = 1'b0;
    int   firstAddr  = -1;
    int   firstColor = -1;
    logic firstBusy  = 1'b0;
    bit   modelOn    = 1'b0;
    int   modelY     = 0;
    bit   expErr     = 1'b0;

    // Counts one comparison and reports it when the values differ.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Colour of one pixel from its two camera bytes, by field arithmetic.
    function automatic int modelPack(input int hi, input int lo);
        return (hi / 32) * 32 + (hi % 8) * 4 + ((lo / 8) % 4);
    endfunction

    // A line of n pixels lands at row modelY; only the first W pixels of the
    // first H non-empty lines are stored.
    task automatic modelLine(input int n, input int hi, input int lo);
        wr_t e;
        if (!modelOn || n == 0) return;
        for (int p = 0; p < n; p++) begin
            if (p < W && modelY < H) begin
                e.addr  = modelY * W + p;
                e.color = modelPack(hi, lo);
                expQ.push_back(e);
            end
        end
        if (modelY < H + 1) modelY++;
    endtask

    // Every cycle: each write must match the next expected one.
    always @(negedge CLOCK) begin
        if (monitorOn) begin
            if (W_EN) begin
                writeCount++;
                lastAddr = int'(W_ADDR);
                if (int'(W_ADDR) > maxAddr) maxAddr = int'(W_ADDR);
                if (grabFirst) begin
                    grabFirst  = 1'b0;
                    firstAddr  = int'(W_ADDR);
                    firstColor = int'(PIXEL_COLOR);
                    firstBusy  = BUSY;
                end
                if (expQ.size() == 0) begin
                    checkOutput("spurious_w_en", W_EN, 0);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("w_addr", W_ADDR, monE.addr);
                    checkOutput("pixel_color", PIXEL_COLOR, monE.color);
                end
            end
            if (FRAME_DONE) doneCount++;
            if (doneSeenPrev) busyAfterDone = BUSY;
            doneSeenPrev = FRAME_DONE;
        end
    end

    task automatic applyStimulus(input bit vs, input bit hr, input int d, input bit st);
        @(posedge CLOCK);
        #1;
        VSYNC = vs;
        HREF  = hr;
        DATA  = 8'(d);
        START = st;
    endtask

    task automatic driveLine(input int n, input int hi, input int lo);
        modelLine(n, hi, lo);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, hi, 1'b0);
            applyStimulus(1'b0, 1'b1, lo, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic frameStart();
        modelY = 0;
        repeat (3) applyStimulus(1'b1, 1'b0, 0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic pulseStart();
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
    endtask

    // Raise VSYNC, wait a bounded time for FRAME_DONE, then check the frame.
    task automatic frameEnd(input bit expectDone, input bit expBusy);
        int prev;
        bit seen;
        prev = doneCount;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus(1'b1, 1'b0, 0, 1'b0);
            @(negedge CLOCK);
            if (doneCount != prev) seen = 1'b1;
        end
        repeat (3) applyStimulus(1'b1, 1'b0, 0, 1'b0);
        @(negedge CLOCK);
        if (expectDone) begin
            if (modelY != H) expErr = 1'b1;
            checkOutput("frame_done_pulses", doneCount - prev, 1);
            checkOutput("busy_after_done", busyAfterDone, expBusy);
            checkOutput("frame_err", FRAME_ERR, expErr);
        end else begin
            checkOutput("frame_done_pulses", doneCount - prev, 0);
        end
        checkOutput("busy", BUSY, expBusy);
        checkOutput("pending_writes", expQ.size(), 0);
    endtask

    task automatic resetDut();
        RESET = 1'b1;
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        @(negedge CLOCK);
        checkOutput("reset_w_en", W_EN, 0);
        checkOutput("reset_w_addr", W_ADDR, 0);
        checkOutput("reset_pixel_color", PIXEL_COLOR, 0);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_frame_done", FRAME_DONE, 0);
        checkOutput("reset_frame_err", FRAME_ERR, 0);
        RESET  = 1'b0;
        expErr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESET      = 1'b1;
        VSYNC      = 1'b1;
        HREF       = 1'b0;
        DATA       = 8'd0;
        START      = 1'b0;
        CONTINUOUS = 1'b0;
        resetDut();
        monitorOn = 1'b1;

        // Arm and capture a single short line of 0xF8,0x1F pixels.
        $display("[TB] arm and first write");
        pulseStart();
        @(negedge CLOCK);
        checkOutput("busy_after_start", BUSY, 1);
        modelOn   = 1'b1;
        grabFirst = 1'b1;
        firstAddr = -1;
        frameStart();
        driveLine(3, 'hF8, 'h1F);
        checkOutput("first_w_addr", firstAddr, 0);
        checkOutput("first_pixel_color", firstColor, 'hE3);
        checkOutput("first_busy", firstBusy, 1);
        frameEnd(1'b1, 1'b0);
        checkOutput("one_line_frame_err", FRAME_ERR, 1);
        resetDut();

        // Exactly HEIGHT lines of WIDTH pixels.
        $display("[TB] full frame");
        pulseStart();
        writeCount = 0;
        maxAddr    = 0;
        frameStart();
        for (int l = 0; l < H; l++) driveLine(W, 'h07, 'hE0);
        frameEnd(1'b1, 1'b0);
        checkOutput("full_write_count", writeCount, 25344);
        checkOutput("full_last_addr", lastAddr, 25343);
        checkOutput("full_frame_err", FRAME_ERR, 0);

        // Overlong lines and too many lines.
        $display("[TB] overlong frame");
        pulseStart();
        writeCount = 0;
        maxAddr    = 0;
        frameStart();
        for (int l = 0; l < 150; l++) driveLine((l < 3 || l >= 140) ? 180 : 4, 'h5A, 'h5A);
        frameEnd(1'b1, 1'b0);
        checkOutput("overlong_write_count", writeCount, 1780);
        checkOutput("overlong_max_addr", maxAddr, 25343);
        checkOutput("overlong_frame_err", FRAME_ERR, 1);
        resetDut();

        // Continuous mode: a short frame, then the next frame starts at 0.
        $display("[TB] continuous short frame");
        CONTINUOUS = 1'b1;
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        frameStart();
        for (int l = 0; l < 100; l++) driveLine(4, 'hAB, 'hCD);
        frameEnd(1'b1, 1'b1);
        checkOutput("short_frame_err", FRAME_ERR, 1);
        grabFirst = 1'b1;
        firstAddr = -1;
        frameStart();
        for (int l = 0; l < 3; l++) driveLine(5, 'h12, 'h34);
        CONTINUOUS = 1'b0;
        checkOutput("cont_first_addr", firstAddr, 0);
        frameEnd(1'b1, 1'b0);

        // Arm in the middle of a frame: nothing until the next VSYNC fall.
        $display("[TB] arm mid-frame");
        modelOn    = 1'b0;
        writeCount = 0;
        repeat (3) applyStimulus(1'b0, 1'b0, 0, 1'b0);
        driveLine(6, 'hF8, 'h1F);
        applyStimulus(1'b0, 1'b1, 'hF8, 1'b1);
        applyStimulus(1'b0, 1'b1, 'h1F, 1'b0);
        applyStimulus(1'b0, 1'b1, 'hF8, 1'b0);
        applyStimulus(1'b0, 1'b1, 'h1F, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        driveLine(6, 'hF8, 'h1F);
        frameEnd(1'b0, 1'b1);
        checkOutput("midframe_write_count", writeCount, 0);
        modelOn = 1'b1;
        frameStart();
        driveLine(4, 'hC3, 'h18);
        driveLine(4, 'hC3, 'h18);
        frameEnd(1'b1, 1'b0);
        checkOutput("rearm_write_count", writeCount, 8);

        // Reset at pixel 50 of line 10.
        $display("[TB] reset during capture");
        pulseStart();
        writeCount = 0;
        frameStart();
        for (int l = 0; l < 10; l++) driveLine(W, 'h07, 'hE0);
        modelLine(50, 'h66, 'h99);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 1'b1, 'h66, 1'b0);
            applyStimulus(1'b0, 1'b1, 'h99, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 'h66, 1'b0);
        applyStimulus(1'b0, 1'b1, 'h99, 1'b0);
        RESET = 1'b1;
        applyStimulus(1'b0, 1'b1, 'h66, 1'b0);
        @(negedge CLOCK);
        checkOutput("rst_mid_w_en", W_EN, 0);
        checkOutput("rst_mid_busy", BUSY, 0);
        RESET  = 1'b0;
        expErr = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("rst_mid_write_count", writeCount, 1810);
        checkOutput("rst_mid_pending", expQ.size(), 0);
        modelOn = 1'b0;
        frameStart();
        driveLine(4, 'h07, 'hE0);
        driveLine(4, 'h07, 'hE0);
        frameEnd(1'b0, 1'b0);
        checkOutput("rst_idle_write_count", writeCount, 1810);
        pulseStart();
        modelOn = 1'b1;
        frameStart();
        driveLine(3, 'h07, 'hE0);
        frameEnd(1'b1, 1'b0);
        checkOutput("rst_rearm_write_count", writeCount, 1813);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
